// File: rtl/btn_spi_tx_ctrl.sv
// btn_spi_tx_ctrl: turns debounced button presses into SPI write requests.
// Presses are queued as a pending count (saturating at PEND_MAX, excess
// presses flagged on o_drop). Each request issues a one-cycle o_start with a
// running transfer index on o_tx_data, waits for i_done, then enforces an
// idle gap of GAP_CYCLES before the next request.
// Optional build macro BTN_SPI_TX_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CYCLES cycles and the o_timeout pulse output.
module btn_spi_tx_ctrl #(
    parameter int DATA_W         = 8,
    parameter int PEND_MAX       = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_btn,
    input  logic                            i_ready,
    input  logic                            i_done,
    output logic                            o_start,
    output logic [DATA_W-1:0]               o_tx_data,
    output logic [$clog2(PEND_MAX+1)-1:0]   o_pend,
    output logic                            o_busy,
    output logic                            o_drop
`ifdef BTN_SPI_TX_TIMEOUT_EN
    ,
    output logic                            o_timeout
`endif
);

    localparam int PEND_W = $clog2(PEND_MAX + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [DATA_W-1:0] IDX_ONE   = DATA_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PEND_W-1:0]   pend;
    logic [DATA_W-1:0]   idx;
    logic [GAP_W-1:0]    gap_cnt;
    logic                issue;
    logic                accept;
    logic                load;
    logic                wait_done;

    // START is the cycle a queued press is consumed; a press arriving in that
    // same cycle is always accepted because a slot is being freed.
    assign issue     = (state == ST_START);
    assign accept    = i_btn && ((pend != PEND_FULL) || issue);
    assign load      = (state == ST_IDLE) && (pend != '0) && i_ready;
    assign wait_done = (state == ST_WAIT) && i_done;

    assign o_start = issue;
    assign o_busy  = (state != ST_IDLE);
    assign o_drop  = i_btn && !accept;
    assign o_pend  = pend;

`ifdef BTN_SPI_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    // A completion arriving on the last watchdog cycle wins over the timeout.
    assign wd_expire = (state == ST_WAIT) && !i_done && (wd_cnt == WD_LAST);
    assign o_timeout = wd_expire;

    // Watchdog: counts cycles spent in WAIT, cleared everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + WD_ONE;
        end else begin
            wd_cnt <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; i_ready matters only in IDLE, i_done only in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_done) begin
                    state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
`ifdef BTN_SPI_TX_TIMEOUT_EN
                else if (wd_expire) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending-press counter: simultaneous accept and issue cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (accept && !issue) begin
            pend <= pend + PEND_ONE;
        end else if (!accept && issue) begin
            pend <= pend - PEND_ONE;
        end
    end

    // Payload is captured on the IDLE->START edge so it lines up with o_start
    // and then holds until the next request; idx advances only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            o_tx_data <= '0;
        end else begin
            if (load) begin
                o_tx_data <= idx;
            end
            if (wait_done) begin
                idx <= idx + IDX_ONE;
            end
        end
    end

    // Gap counter: runs 0..GAP_CYCLES-1 while in GAP, idle at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if ((state == ST_GAP) && (gap_cnt != GAP_LAST)) begin
            gap_cnt <= gap_cnt + GAP_ONE;
        end else begin
            gap_cnt <= '0;
        end
    end

endmodule

// File: doc/btn_spi_tx_ctrl.md
Name: btn_spi_tx_ctrl

Overview:
- Consumes the single-cycle press pulse from the button debouncer and turns each press into one SPI write request to the SPI master.
- Queues presses as a pending count, then issues start/data to the master with a ready/done handshake.
- Transmits a running transfer index as the payload.
- Sits between the button debouncer and the SPI master.

Parameters:
- DATA_W, 8, payload width and transfer-index width.
- PEND_MAX, 4, maximum queued presses (>=1).
- GAP_CYCLES, 16, idle clk cycles enforced after each done (0 = no gap).
- TIMEOUT_CYCLES, 1024, WAIT watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_btn  in  1  debounced single-cycle press pulse.
- i_ready  in  1  SPI master idle and able to accept a start.
- i_done  in  1  SPI master transfer-complete pulse.
- o_start  out  1  one-cycle start strobe to the SPI master.
- o_tx_data  out  DATA_W  payload to the SPI master.
- o_pend  out  $clog2(PEND_MAX+1)  current pending-press count.
- o_busy  out  1  high in every state except IDLE.
- o_drop  out  1  one-cycle pulse when a press is lost because the queue is full.

Behaviour:
- Reset (async, any state): FSM=IDLE; pend=0; idx=0; gap counter=0; all outputs 0 (o_tx_data=0).
- Pending counter:
  - +1 on i_btn when pend<PEND_MAX.
  - -1 in the START cycle.
  - i_btn and START in the same cycle: pend unchanged.
  - i_btn while pend==PEND_MAX and no START that cycle: pend stays, o_drop=1 for that cycle.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE: if pend>0 && i_ready, go to START next cycle. Otherwise stay.
  - START (exactly 1 cycle): o_start=1, o_tx_data<=idx (registered, so visible in the same cycle as o_start), pend decrements. Next state is WAIT.
  - WAIT: hold o_tx_data stable. On i_done: idx<=idx+1 (wraps 2^DATA_W-1 -> 0); go to GAP, or to IDLE if GAP_CYCLES==0.
  - GAP: count GAP_CYCLES cycles (counter 0..GAP_CYCLES-1), then IDLE. Presses during GAP still queue.
- i_done outside WAIT is ignored. i_ready is sampled only in IDLE.
- o_tx_data holds its last value until the next START.
- Latency: with pend>0 and i_ready=1 in IDLE, o_start rises 1 cycle later. With pend=0 in IDLE, i_btn at cycle n gives pend=1 at n+1 and o_start at n+2.
- Back-to-back: a request queued during WAIT/GAP is issued from IDLE with no extra bubble beyond the IDLE->START cycle.
- o_busy = (state != IDLE), combinational from the state register.
- Width rule: idx and o_tx_data are DATA_W bits, unsigned, wrapping. pend never exceeds PEND_MAX and never goes below 0.

Optional Feature:
- Macro: BTN_SPI_TX_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT. If TIMEOUT_CYCLES elapse without i_done, the FSM goes to IDLE and extra output o_timeout (out, 1) pulses for one cycle.
  - idx is not incremented; the request counts as consumed (pend is not restored).
  - i_done in the same cycle the limit is reached takes priority (normal completion).
- Undefined: no o_timeout port and no watchdog logic; WAIT waits indefinitely for i_done.

Test Plan:
- Reset, one press: rst pulse, i_ready=1, single i_btn -> o_start 2 cycles later with o_tx_data=0x00. i_done 5 cycles after that -> GAP of 16 cycles, then IDLE, o_busy=0, next press sends 0x01.
- Queue overflow: i_ready=0, 6 presses -> o_pend=4, o_drop pulses on presses 5 and 6. Raise i_ready -> 4 transfers with data 0x00..0x03, o_pend ends at 0.
- Simultaneous: i_btn in the same cycle as START with pend=1 -> o_pend stays 1 and a second transfer follows.
- Wrap: force 256 completed transfers -> payload sequence 0xFF then 0x00.
- Reset mid-WAIT: assert rst during WAIT -> o_start=0, o_busy=0, o_pend=0, o_tx_data=0 immediately (async). A later press sends 0x00.
- With BTN_SPI_TX_TIMEOUT_EN and TIMEOUT_CYCLES=8: withhold i_done -> o_timeout after 8 WAIT cycles, FSM to IDLE, next payload repeats the same idx.
